// File: rtl/multi_pkg.sv
// Shared encodings for the multicycle main controller: state codes,
// opcode classes and datapath mux selects.
package multi_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    // ALU A: register operand or old PC
    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    // ALU B: register operand, extended immediate, constant 4
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    // Result: registered ALU output, memory read data, live ALU result
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multi_mainfsm.sv
// Multicycle processor main controller: sequences fetch/decode/execute
// and drives datapath selects and one-shot write strobes.
module multi_mainfsm
    import multi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       irwrite,
    output logic       nextpc,
    output logic       regw,
    output logic       memw,
    output logic       branch,
    output logic       aluop,
    output logic       adrsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic [3:0] state,
    output logic       illegal
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so nothing writes while the state is
    // being forced back to FETCH.
    always_comb begin
        irwrite   = 1'b0;
        nextpc    = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        illegal   = 1'b0;
        aluop     = 1'b0;
        adrsrc    = 1'b0;
        alusrca   = SRCA_REG;
        alusrcb   = SRCB_REG;
        resultsrc = RES_ALUOUT;
        case (state_q)
            S_FETCH: begin
                alusrca   = SRCA_PC;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                irwrite   = mem_ready & reset;
                nextpc    = mem_ready & reset;
            end
            S_DECODE: begin
                alusrca   = SRCA_PC;
                alusrcb   = SRCB_FOUR;
                resultsrc = RES_ALU;
                illegal   = (op == OP_UNDEF) & reset;
            end
            S_MEMADR:   alusrcb = SRCB_IMM;
            S_MEMRD:    adrsrc  = 1'b1;
            S_MEMWB: begin
                resultsrc = RES_DATA;
                regw      = reset;
            end
            S_MEMWR: begin
                adrsrc = 1'b1;
                memw   = mem_ready & reset;
            end
            S_EXECUTER: aluop = 1'b1;
            S_EXECUTEI: begin
                alusrcb = SRCB_IMM;
                aluop   = 1'b1;
            end
            S_ALUWB:    regw = reset;
            S_BRANCH: begin
                alusrcb   = SRCB_IMM;
                resultsrc = RES_ALU;
                branch    = reset;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/multi_mainfsm.md
MULTI_MAINFSM -- requirements
Module: multi_mainfsm

Interface
REQ-001 Parameters: none; all encodings are fixed constants.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 op  in  2  instruction Op field (00 data-proc, 01 memory, 10 branch, 11 undefined).
REQ-005 funct  in  6  instruction Funct field; funct[5]=I (immediate), funct[0]=L (load) / S.
REQ-006 mem_ready  in  1  unified memory completes access this cycle.
REQ-007 irwrite, nextpc, regw, memw, branch, aluop  out  1 each  datapath strobes/selects.
REQ-008 adrsrc  out  1  0 = PC address, 1 = ALU result address.
REQ-009 alusrca  out  2  ALU A source select; alusrcb out 2 ALU B source select.
REQ-010 resultsrc  out  2  result mux select.
REQ-011 state  out  4  current state code (debug/bench visibility).
REQ-012 illegal  out  1  one-cycle pulse on undefined op decode.

Function
REQ-013 States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 unused.
REQ-014 FETCH: adrsrc=0, alusrca=01, alusrcb=10, aluop=0, resultsrc=10; irwrite=nextpc=mem_ready; stays in FETCH while mem_ready=0, else -> DECODE.
REQ-015 DECODE: alusrca=01, alusrcb=10, resultsrc=10; op=01 -> MEMADR; op=00 & funct[5]=0 -> EXECUTER; op=00 & funct[5]=1 -> EXECUTEI; op=10 -> BRANCH; op=11 -> FETCH with illegal=1 that cycle.
REQ-016 MEMADR: alusrca=00, alusrcb=01, aluop=0; funct[0]=1 -> MEMRD, else -> MEMWR.
REQ-017 MEMRD: adrsrc=1, resultsrc=00; hold while mem_ready=0, else -> MEMWB.
REQ-018 MEMWB: resultsrc=01, regw=1 -> FETCH.
REQ-019 MEMWR: adrsrc=1, resultsrc=00, memw=mem_ready; hold while mem_ready=0, else -> FETCH.
REQ-020 EXECUTER: alusrca=00, alusrcb=00, aluop=1 -> ALUWB; EXECUTEI: same but alusrcb=01 -> ALUWB.
REQ-021 ALUWB: resultsrc=00, regw=1 -> FETCH.
REQ-022 BRANCH: alusrca=00, alusrcb=01, aluop=0, resultsrc=10, branch=1 -> FETCH.
REQ-023 All outputs not listed for a state drive 0; outputs are purely combinational from state, op, funct, mem_ready (Moore except mem_ready-qualified strobes and illegal).
REQ-024 Strobes irwrite, nextpc, memw, regw, branch each assert at most one cycle per instruction.
REQ-025 op/funct sampled only in DECODE and MEMADR; changes elsewhere have no effect.
REQ-026 Unused state codes -> FETCH next cycle, all strobes 0.

Reset
REQ-027 reset=0 forces state=FETCH immediately, asynchronously, including mid-instruction.
REQ-028 While reset=0: irwrite, nextpc, regw, memw, branch, illegal = 0.
REQ-029 First rising edge after reset deassert with mem_ready=1 performs a fetch (FETCH -> DECODE).

Structure
REQ-030 State codes and alusrca/alusrcb/resultsrc encodings live in shared package multi_pkg.
REQ-031 Single module, next-state and output logic in separate combinational blocks; no sub-module.

Verification
REQ-032 Reset low mid-MEMRD -> state=0 same cycle, all strobes 0; release, mem_ready=1 -> irwrite=nextpc=1, then state=1.
REQ-033 op=00, funct=6'b000000, mem_ready=1 -> state sequence 0,1,6,8,0; regw=1 only in state 8.
REQ-034 op=01, funct[0]=1, mem_ready low 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0; regw once.
REQ-035 op=01, funct[0]=0 -> 0,1,2,5,0; memw=1 exactly one cycle, adrsrc=1 in state 5.
REQ-036 op=10 -> 0,1,9,0, branch=1 one cycle; op=11 -> 0,1,0 with illegal=1 in DECODE.
REQ-037 mem_ready=0 held 3 cycles in FETCH -> state stays 0, irwrite=nextpc=0 until mem_ready=1.
